// File: rtl/serial_sram_ctrl_bridge.sv
// Serial pin loader for the on-chip SRAM: shift/read/write/burst-write with CPU port arbitration.
// Optional build macro SCTRL_LOAD_SYNC_EN adds a 2-flop LOAD_N synchroniser (+2 cycles latency).
module serial_sram_ctrl_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int SR_W   = ADDR_W + DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        CTRL_MODE,
  input  logic              LOAD_N,
  input  logic              CTRL_SI,
  input  logic              CPU_OWN,
  output logic              CTRL_RDY,
  output logic              CTRL_SO,
  output logic              SRAM_REQ,
  output logic              SRAM_CEN,
  output logic              SRAM_WEN,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_D,
  input  logic [DATA_W-1:0] SRAM_Q
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_BUS_WAIT, S_WR, S_RD, S_RD_CAP, S_DONE
  } state_t;

  localparam logic [1:0] M_SHIFT = 2'b00;
  localparam logic [1:0] M_READ  = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;
  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t          r_state, w_next;
  logic [SR_W-1:0] r_sreg, w_sreg;
  logic [1:0]      r_mode;
  logic            r_si;
  logic            r_ld_q;
  logic            w_ld_s;
  logic            w_fall;

`ifdef SCTRL_LOAD_SYNC_EN
  logic [1:0] r_ld_sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_ld_sync <= 2'b00;
    else        r_ld_sync <= {r_ld_sync[0], LOAD_N};
  end

  assign w_ld_s = r_ld_sync[1];
`else
  assign w_ld_s = LOAD_N;
`endif

  // ld_q resets low so a strobe held low through reset never looks like a new edge
  assign w_fall = r_ld_q & ~w_ld_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_mode  <= 2'b00;
      r_si    <= 1'b0;
      r_ld_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sreg  <= w_sreg;
      r_ld_q  <= w_ld_s;
      if (r_state == S_IDLE && w_fall) begin
        r_mode <= CTRL_MODE;
        r_si   <= CTRL_SI;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_sreg = r_sreg;
    case (r_state)
      S_IDLE:     if (w_fall) w_next = (CTRL_MODE == M_SHIFT) ? S_SHIFT : S_BUS_WAIT;
      S_SHIFT: begin
        w_sreg = {r_si, r_sreg[SR_W-1:1]};
        w_next = S_DONE;
      end
      S_BUS_WAIT: if (!CPU_OWN) w_next = (r_mode == M_READ) ? S_RD : S_WR;
      S_WR: begin
        w_next = S_DONE;
        if (r_mode == M_BURST) w_sreg[SR_W-1:DATA_W] = r_sreg[SR_W-1:DATA_W] + A_ONE;
      end
      S_RD:       w_next = S_RD_CAP;
      S_RD_CAP: begin
        w_sreg[DATA_W-1:0] = SRAM_Q;
        w_next = S_DONE;
      end
      S_DONE:     if (w_ld_s) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign CTRL_RDY = (r_state == S_DONE);
  assign SRAM_REQ = (r_state == S_BUS_WAIT) || (r_state == S_WR) ||
                    (r_state == S_RD) || (r_state == S_RD_CAP);
  assign SRAM_CEN = ~((r_state == S_WR) || (r_state == S_RD));
  assign SRAM_WEN = ~(r_state == S_WR);
  assign CTRL_SO  = r_sreg[0];
  assign SRAM_A   = r_sreg[SR_W-1:DATA_W];
  assign SRAM_D   = r_sreg[DATA_W-1:0];

endmodule

// File: tb/tb_serial_sram_ctrl_bridge.sv
// Self-checking bench for serial_sram_ctrl_bridge: SRAM access scoreboard plus per-feature tasks.
module tb_serial_sram_ctrl_bridge;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int SW = AW + DW;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic [1:0]    CTRL_MODE = 2'b00;
  logic          LOAD_N = 1'b1;
  logic          CTRL_SI = 1'b0;
  logic          CPU_OWN = 1'b0;
  logic          CTRL_RDY, CTRL_SO, SRAM_REQ, SRAM_CEN, SRAM_WEN;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] SRAM_D;
  logic [DW-1:0] SRAM_Q;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;

  acc_t          exp_q[$];
  acc_t          mon_e;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [SW-1:0] m_sreg;
  int            checks = 0;
  int            errors = 0;

  serial_sram_ctrl_bridge #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .CTRL_MODE(CTRL_MODE), .LOAD_N(LOAD_N),
    .CTRL_SI(CTRL_SI), .CPU_OWN(CPU_OWN), .CTRL_RDY(CTRL_RDY), .CTRL_SO(CTRL_SO),
    .SRAM_REQ(SRAM_REQ), .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN),
    .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  always #5 CLK = ~CLK;

  // synchronous SRAM model
  always @(posedge CLK) begin
    if (SRAM_CEN === 1'b0) begin
      if (SRAM_WEN === 1'b0) mem[SRAM_A] <= SRAM_D;
      else                   SRAM_Q <= mem[SRAM_A];
    end
  end

  // every CEN-low cycle must match the next expected access
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && SRAM_CEN === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL access: unexpected CEN low A=%h WEN=%b D=%h", SRAM_A, SRAM_WEN, SRAM_D);
      end else begin
        mon_e = exp_q.pop_front();
        if (SRAM_WEN !== ~mon_e.we || SRAM_A !== mon_e.a || (mon_e.we && SRAM_D !== mon_e.d)) begin
          errors++;
          $display("FAIL access: got WEN=%b A=%h D=%h, want WEN=%b A=%h D=%h",
                   SRAM_WEN, SRAM_A, SRAM_D, ~mon_e.we, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_cmd(input logic [1:0] mode, input logic si, input int lat, input string nm);
    int n;
    n = 0;
    CTRL_MODE = mode; CTRL_SI = si; LOAD_N = 1'b0;
    do begin step(); n++; end while (CTRL_RDY !== 1'b1 && n < 20);
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want %0d", nm, n, lat);
    end
    LOAD_N = 1'b1;
    step();
    checks++;
    if (CTRL_RDY !== 1'b0) begin
      errors++;
      $display("FAIL %s rdy_clear: got %b, want 0", nm, CTRL_RDY);
    end
  endtask

  task automatic shift_bits(input logic [SW-1:0] v, input int nb, input string nm);
    for (int i = 0; i < nb; i++) begin
      m_sreg = {v[i], m_sreg[SW-1:1]};
      do_cmd(2'b00, v[i], 2, nm);
    end
    checks++;
    if (SRAM_A !== m_sreg[SW-1:DW] || SRAM_D !== m_sreg[DW-1:0]) begin
      errors++;
      $display("FAIL %s sreg: got A=%h D=%h, want A=%h D=%h", nm, SRAM_A, SRAM_D,
               m_sreg[SW-1:DW], m_sreg[DW-1:0]);
    end
  endtask

  task automatic write_cmd(input logic [1:0] mode, input string nm);
    exp_q.push_back({1'b1, m_sreg[SW-1:DW], m_sreg[DW-1:0]});
    do_cmd(mode, 1'b0, 3, nm);
    if (mode == 2'b10) m_sreg[SW-1:DW] = m_sreg[SW-1:DW] + 9'd1;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    step(); step();
    checks++;
    if ({CTRL_RDY, SRAM_REQ, SRAM_CEN, SRAM_WEN, CTRL_SO} !== 5'b00110) begin
      errors++;
      $display("FAIL reset_ctrl: got RDY/REQ/CEN/WEN/SO=%b, want 00110",
               {CTRL_RDY, SRAM_REQ, SRAM_CEN, SRAM_WEN, CTRL_SO});
    end
    checks++;
    if (SRAM_A !== '0 || SRAM_D !== '0) begin
      errors++;
      $display("FAIL reset_data: got A=%h D=%h, want 0 0", SRAM_A, SRAM_D);
    end
    RST_N = 1'b1;
    m_sreg = '0;
    step(); step();
  endtask

  task automatic test_write();
    shift_bits({9'h020, 8'h3C}, SW, "wr_shift");
    write_cmd(2'b11, "write");
  endtask

  task automatic test_read();
    logic [DW-1:0] got;
    shift_bits({8'h00, 9'h020}, AW, "rd_addr");
    exp_q.push_back({1'b0, m_sreg[SW-1:DW], 8'h00});
    do_cmd(2'b01, 1'b0, 4, "read");
    m_sreg[DW-1:0] = 8'h3C;
    checks++;
    if (SRAM_A !== 9'h020 || SRAM_D !== 8'h3C) begin
      errors++;
      $display("FAIL read_cap: got A=%h D=%h, want 020 3c", SRAM_A, SRAM_D);
    end
    for (int i = 0; i < DW; i++) begin
      got[i] = CTRL_SO;
      m_sreg = {1'b0, m_sreg[SW-1:1]};
      do_cmd(2'b00, 1'b0, 2, "so_shift");
    end
    checks++;
    if (got !== 8'h3C) begin
      errors++;
      $display("FAIL read_so: got %h, want 3c", got);
    end
  endtask

  task automatic test_burst();
    shift_bits({9'h1FF, 8'hA5}, SW, "bw_shift");
    write_cmd(2'b10, "burst0");
    checks++;
    if (SRAM_A !== 9'h000 || SRAM_D !== 8'hA5) begin
      errors++;
      $display("FAIL burst_wrap: got A=%h D=%h, want 000 a5", SRAM_A, SRAM_D);
    end
    write_cmd(2'b10, "burst1");
    shift_bits({9'h000, 8'h5A}, DW, "bw_reshift");
    write_cmd(2'b10, "burst2");
  endtask

  task automatic test_cpu_own();
    shift_bits({9'h0AB, 8'hC3}, SW, "own_shift");
    exp_q.push_back({1'b1, 9'h0AB, 8'hC3});
    CPU_OWN = 1'b1;
    CTRL_MODE = 2'b11; LOAD_N = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (SRAM_REQ !== 1'b1 || SRAM_CEN !== 1'b1 || CTRL_RDY !== 1'b0) begin
        errors++;
        $display("FAIL own_wait: cycle %0d got REQ=%b CEN=%b RDY=%b, want 1 1 0",
                 i, SRAM_REQ, SRAM_CEN, CTRL_RDY);
      end
      step();
    end
    CPU_OWN = 1'b0;
    step();
    checks++;
    if (SRAM_CEN !== 1'b0 || SRAM_WEN !== 1'b0) begin
      errors++;
      $display("FAIL own_write: got CEN=%b WEN=%b, want 0 0", SRAM_CEN, SRAM_WEN);
    end
    step();
    checks++;
    if (CTRL_RDY !== 1'b1 || SRAM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL own_rdy: got RDY=%b REQ=%b, want 1 0", CTRL_RDY, SRAM_REQ);
    end
    LOAD_N = 1'b1;
    step();
  endtask

  task automatic test_glitch();
    int n;
    exp_q.push_back({1'b1, 9'h0AB, 8'hC3});
    CPU_OWN = 1'b1;
    CTRL_MODE = 2'b11; LOAD_N = 1'b0;
    step(); step();
    LOAD_N = 1'b1; step();
    LOAD_N = 1'b0; step(); step();
    CPU_OWN = 1'b0;
    n = 0;
    while (CTRL_RDY !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL glitch_rdy: got %0d cycles, want 2", n);
    end
    step(); step();
    checks++;
    if (CTRL_RDY !== 1'b1) begin
      errors++;
      $display("FAIL glitch_hold: got RDY=%b, want 1", CTRL_RDY);
    end
    LOAD_N = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (exp_q.size() != 0 || CTRL_RDY !== 1'b0) begin
      errors++;
      $display("FAIL glitch_once: got pending=%0d RDY=%b, want 0 0", exp_q.size(), CTRL_RDY);
    end
  endtask

  task automatic test_rdy_pulse();
    int hi;
    exp_q.push_back({1'b1, 9'h0AB, 8'hC3});
    CPU_OWN = 1'b1;
    CTRL_MODE = 2'b11; LOAD_N = 1'b0;
    step(); step();
    LOAD_N = 1'b1; step(); step();
    CPU_OWN = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin step(); if (CTRL_RDY === 1'b1) hi++; end
    checks++;
    if (hi != 1) begin
      errors++;
      $display("FAIL rdy_pulse: got %0d high cycles, want 1", hi);
    end
  endtask

  task automatic test_reset_mid_write();
    CTRL_MODE = 2'b11; LOAD_N = 1'b0;
    step(); step();
    checks++;
    if (SRAM_CEN !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_inwr: got CEN=%b, want 0", SRAM_CEN);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (SRAM_CEN !== 1'b1 || SRAM_WEN !== 1'b1 || CTRL_RDY !== 1'b0 ||
        SRAM_A !== '0 || SRAM_D !== '0) begin
      errors++;
      $display("FAIL rst_mid: got CEN=%b WEN=%b RDY=%b A=%h D=%h, want 1 1 0 0 0",
               SRAM_CEN, SRAM_WEN, CTRL_RDY, SRAM_A, SRAM_D);
    end
    step(); step();
    RST_N = 1'b1;
    m_sreg = '0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (SRAM_CEN !== 1'b1 || CTRL_RDY !== 1'b0 || SRAM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got CEN=%b RDY=%b REQ=%b, want 1 0 0", SRAM_CEN, CTRL_RDY, SRAM_REQ);
    end
    LOAD_N = 1'b1;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst();
    test_cpu_own();
    test_glitch();
    test_rdy_pulse();
    test_reset_mid_write();
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending accesses, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
